// File: rtl/uart_rx.sv
// uart_rx: receiver for 10-bit UART frames (start 0, 8 data bits LSB first,
// stop 1) arriving from an RS485 transceiver. The line is oversampled at
// CLKS_PER_BIT system clocks per bit, and every decision is made on a single
// mid-bit sample of the synchronised line. A good frame updates dout and
// pulses rdy for one cycle. A low stop bit pulses ferr once, and the receiver
// then waits out the break until the line returns high.
module uart_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rs485_rx,
   output logic [7:0] dout,
   output logic       rdy,
   output logic       ferr,
   output logic       busy,
   output logic [2:0] dbg_state
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   // There is no valid/ready handshake on the output side. rdy is a
   // one-cycle strobe that qualifies dout. The consumer has to take dout in
   // that cycle or read it later, before the next good frame overwrites it.

   state_t        state_q, state_d;
   logic          rx_meta_q, rx_meta_d;
   logic          rx_s_q, rx_s_d;
   logic [CW-1:0] clk_cnt_q, clk_cnt_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    dout_q, dout_d;
   logic          rdy_q, rdy_d;
   logic          ferr_q, ferr_d;

   logic          cnt_half;
   logic          cnt_full;

   assign cnt_half = (clk_cnt_q == HALF_M1);
   assign cnt_full = (clk_cnt_q == FULL_M1);

   // State register and all datapath flops. The synchroniser resets to idle-high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         dout_q    <= '0;
         rdy_q     <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rx_meta_q <= rx_meta_d;
         rx_s_q    <= rx_s_d;
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         dout_q    <= dout_d;
         rdy_q     <= rdy_d;
         ferr_q    <= ferr_d;
      end
   end

   // Next-state logic. A single mid-bit sample decides each transition.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!rx_s_q) state_d = S_START;
         S_START: if (cnt_half) state_d = rx_s_q ? S_IDLE : S_DATA;
         S_DATA:  if (cnt_full && (bit_cnt_q == 3'd7)) state_d = S_STOP;
         S_STOP:  if (cnt_full) state_d = rx_s_q ? S_IDLE : S_BREAK;
         S_BREAK: if (rx_s_q) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath: the synchroniser, the bit-timing counters, the shift register and the result flops.
   always_comb begin
      rx_meta_d = rs485_rx;
      rx_s_d    = rx_meta_q;
      clk_cnt_d = clk_cnt_q + CW'(1);
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      dout_d    = dout_q;
      rdy_d     = 1'b0;
      ferr_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            clk_cnt_d = '0;
            bit_cnt_d = '0;
         end
         S_START: begin
            if (cnt_half) clk_cnt_d = '0;
         end
         S_DATA: begin
            if (cnt_full) begin
               clk_cnt_d = '0;
               // Shift right with the new bit entering at the MSB. After eight
               // samples, the first bit received sits in bit 0.
               shift_d   = {rx_s_q, shift_q[7:1]};
               // The counter wraps from 7 back to 0 as the FSM enters STOP.
               bit_cnt_d = bit_cnt_q + 3'd1;
            end
         end
         S_STOP: begin
            if (cnt_full) begin
               clk_cnt_d = '0;
               if (rx_s_q) begin
                  dout_d = shift_q;
                  rdy_d  = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end
         end
         S_BREAK: begin
            clk_cnt_d = '0;
         end
         default: begin
            clk_cnt_d = '0;
         end
      endcase
   end

   // Output decode. busy is high in every state except IDLE.
   always_comb begin
      busy      = (state_q != S_IDLE);
      dout      = dout_q;
      rdy       = rdy_q;
      ferr      = ferr_q;
      dbg_state = state_q;
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: a scoreboard bench for uart_rx. The driver serialises frames and
// queues the expected data byte or framing error, together with the clock
// cycle in which that pulse must appear. A monitor running on the falling
// clock edge pops an entry and checks it each time rdy or ferr pulses.
module tb_uart_rx;

   localparam int N       = 16;
   localparam int LATENCY = 2 + N / 2 + 9 * N + 1;

   logic       clk;
   logic       rst_n;
   logic       rs485_rx;
   logic [7:0] dout;
   logic       rdy;
   logic       ferr;
   logic       busy;
   logic [2:0] dbg_state;

   int tests;
   int fails;
   int cyc;
   int pulse_cnt;

   logic [7:0] exp_q[$];
   int         exp_cyc_q[$];
   int         ferr_cyc_q[$];
   logic [7:0] model_dout;

   uart_rx #(.CLKS_PER_BIT(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rs485_rx  (rs485_rx),
      .dout      (dout),
      .rdy       (rdy),
      .ferr      (ferr),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // Clock generation and the cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   // Driver tasks. Every line change happens 1 time unit after a rising clock edge.
   task automatic hold_line(input logic b, input int clocks);
      rs485_rx = b;
      repeat (clocks) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit);
      logic [9:0] bits;
      bits = {stop_bit, d, 1'b0};
      if (stop_bit) begin
         exp_q.push_back(d);
         exp_cyc_q.push_back(cyc + LATENCY);
      end else begin
         ferr_cyc_q.push_back(cyc + LATENCY);
      end
      for (int i = 0; i < 10; i++) hold_line(bits[i], N);
   endtask

   // Monitor and scoreboard: check every pulse against the expected queues
   always @(negedge clk) begin
      if (rdy && ferr) check("rdy_and_ferr_together", 1, 0);
      if (rdy) begin
         pulse_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_rdy", 1, 0);
         end else begin
            logic [7:0] e;
            int         ec;
            e  = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            check("rdy_dout", dout, e);
            check("rdy_latency_cycle", cyc, ec);
            model_dout = e;
         end
      end
      if (ferr) begin
         pulse_cnt++;
         if (ferr_cyc_q.size() == 0) begin
            check("unexpected_ferr", 1, 0);
         end else begin
            int ec;
            ec = ferr_cyc_q.pop_front();
            check("ferr_cycle", cyc, ec);
            check("ferr_dout_held", dout, model_dout);
         end
      end
   end

   // Stimulus sequence
   initial begin
      int p0;
      int saw_busy;
      int gap;
      logic [7:0] d;
      logic ok;
      logic [9:0] fb;

      tests      = 0;
      fails      = 0;
      pulse_cnt  = 0;
      model_dout = 8'h00;
      rst_n      = 1'b0;
      rs485_rx   = 1'b1;

      // Reset state while rst_n is held low
      repeat (3) @(posedge clk);
      #1;
      check("reset_dout", dout, 0);
      check("reset_rdy", rdy, 0);
      check("reset_ferr", ferr, 0);
      check("reset_busy", busy, 0);
      rst_n = 1'b1;

      // An idle line after reset must produce no pulses
      p0 = pulse_cnt;
      hold_line(1'b1, 200);
      check("idle_no_pulses", pulse_cnt - p0, 0);
      check("idle_busy", busy, 0);

      // Single frame 0xA5: the monitor checks the byte and the 155-cycle latency
      send_frame(8'hA5, 1'b1);
      hold_line(1'b1, 2 * N);
      check("a5_dout", dout, 8'hA5);

      // Back-to-back 0x00 then 0xFF with no idle bits between the frames
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      hold_line(1'b1, 2 * N);
      check("b2b_dout", dout, 8'hFF);

      // Glitch rejection: a 3-clock low pulse starts a frame that must abort
      p0 = pulse_cnt;
      hold_line(1'b0, 3);
      rs485_rx = 1'b1;
      saw_busy = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (busy) saw_busy = 1;
      end
      check("glitch_busy_seen", saw_busy, 1);
      @(posedge clk);
      #1;
      hold_line(1'b1, 20);
      check("glitch_busy_cleared", busy, 0);
      check("glitch_no_pulses", pulse_cnt - p0, 0);
      send_frame(8'h3C, 1'b1);
      hold_line(1'b1, 2 * N);
      check("after_glitch_dout", dout, 8'h3C);

      // Framing error followed by a long break: one ferr, no rdy, busy stays high
      p0 = pulse_cnt;
      send_frame(8'h55, 1'b0);
      for (int i = 0; i < 30; i++) begin
         hold_line(1'b0, N);
         if (i == 5 || i == 29) check("break_busy", busy, 1);
      end
      check("break_one_pulse", pulse_cnt - p0, 1);
      check("break_dout_held", dout, 8'h3C);
      hold_line(1'b1, 2 * N);
      check("break_exit_busy", busy, 0);
      send_frame(8'h81, 1'b1);
      hold_line(1'b1, 2 * N);
      check("after_break_dout", dout, 8'h81);

      // Reset in the middle of data bit 4 clears the outputs and loses the frame
      p0 = pulse_cnt;
      fb = {1'b1, 8'h5A, 1'b0};
      for (int i = 0; i < 5; i++) hold_line(fb[i], N);
      hold_line(fb[5], N / 2);
      #2;
      rst_n = 1'b0;
      model_dout = 8'h00;
      #1;
      check("midreset_dout", dout, 0);
      check("midreset_rdy", rdy, 0);
      check("midreset_ferr", ferr, 0);
      check("midreset_busy", busy, 0);
      rs485_rx = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b1;
      hold_line(1'b1, 3);
      send_frame(8'hC3, 1'b1);
      hold_line(1'b1, 2 * N);
      check("midreset_lost_frame", pulse_cnt - p0, 1);
      check("after_reset_dout", dout, 8'hC3);

      // Random frames with occasional framing errors and random idle gaps
      for (int f = 0; f < 16; f++) begin
         d  = 8'($urandom_range(0, 255));
         ok = ($urandom_range(0, 4) != 0);
         send_frame(d, ok);
         gap = ok ? $urandom_range(0, 2) : 1 + $urandom_range(0, 1);
         if (gap != 0) hold_line(1'b1, gap * N + $urandom_range(0, 7));
      end

      // Drain with a bounded wait, then confirm no expected pulse was missed
      for (int i = 0; i < 400; i++) begin
         if (exp_q.size() == 0 && ferr_cyc_q.size() == 0) break;
         @(posedge clk);
      end
      hold_line(1'b1, 4);
      check("rdy_queue_drained", exp_q.size(), 0);
      check("ferr_queue_drained", ferr_cyc_q.size(), 0);
      check("final_dout", dout, model_dout);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

RS485 UART receiver: recovers 10-bit frames from the serial line and presents the 8 data bits with a one-cycle ready strobe. Frame format is start bit (0), 8 data bits LSB first, stop bit (1). This matches the format our transmitter shifts out as din[0]..din[9]. The block sits between the RS485 transceiver RO pin and the frame/command logic. It oversamples the line at CLKS_PER_BIT system clocks per bit.

## Interface
- CLKS_PER_BIT, 16, system clocks per serial bit; even, ≥4
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- rs485_rx  input  1  serial line, asynchronous to clk, idles high
- dout  output  8  last received data byte; held until next good frame
- rdy  output  1  one-cycle pulse: good frame received, dout valid
- ferr  output  1  one-cycle pulse: stop bit sampled low (framing error)
- busy  output  1  high while a frame is being received (any state except IDLE)

## Operation
- rs485_rx passes through a 2-FF synchronizer (reset value 1) giving rx_s; all decisions use rx_s only.
- State machine: IDLE, START, DATA, STOP, BREAK.
- IDLE: bit counter cleared, clock counter cleared. rx_s==0 → START.
- START: count to the middle of the start bit. At the mid-start sample, rx_s==1 means a glitch: → IDLE, no pulse. rx_s==0 → DATA.
- DATA: sample rx_s every CLKS_PER_BIT clocks. Shift into an 8-bit register LSB first (first sampled bit → bit 0). After the 8th sample → STOP.
- STOP: one bit time later, sample rx_s.
  - rx_s==1: dout ← shift register, rdy pulse, → IDLE.
  - rx_s==0: dout unchanged, ferr pulse, → BREAK.
- BREAK: wait until rx_s==1, then → IDLE. No rdy or ferr while held low, so a long break gives exactly one ferr.
- Single-sample decisions: no majority vote.
- Clock counter width is clog2(CLKS_PER_BIT). Bit counter is 3 bits and wraps 7→0 on entering STOP.
- Reset (asynchronous, any time including mid-frame):
  - state IDLE, counters 0, shift register 0, synchronizer 1
  - outputs: dout=0x00, rdy=0, ferr=0, busy=0
  - First frame after rst_n deasserts is received normally if its start edge arrives after deassertion.

## Timing
- T0 = first cycle rx_s is seen low in IDLE. Let H = CLKS_PER_BIT/2 and N = CLKS_PER_BIT.
- Mid-start sample at T0+H.
- Data bit k (k=0..7) sampled at T0+H+(k+1)·N.
- Stop bit sampled at T0+H+9N.
- rdy/ferr/dout are registered at the stop-sample edge and visible in the following cycle for exactly one cycle.
- busy rises at T0+1 and falls in the same cycle rdy rises. After ferr, busy falls when BREAK exits.
- rx_s lags rs485_rx by 2 clocks. End-to-end latency from the line falling edge to rdy is 2+H+9N+1 clocks; 2+8+144+1 = 155 at N=16.
- The receiver is back in IDLE at mid-stop, so a following start bit with zero idle time is caught. Tolerable baud mismatch is about ±4% per frame.
- No handshake and no buffering: a consumer that misses rdy loses nothing structurally, but dout is overwritten by the next good frame.
- rdy and ferr are never high in the same cycle.

## Test plan
- Reset then idle line: with N=16, hold rst_n=0 and check dout=0x00, rdy=0, ferr=0, busy=0. Release and keep the line high for 200 clocks → no pulses.
- Single frame 0xA5 at 16 clk/bit: drive bits 0,1,0,1,0,0,1,0,1,1 → exactly one rdy pulse, 155 clocks after the falling edge, with dout=0xA5 and ferr=0.
- Back-to-back frames 0x00 then 0xFF with no idle bits between → two rdy pulses 160 clocks apart, dout=0x00 then 0xFF.
- Glitch rejection: line low for 3 clocks, then high → busy pulses briefly, then returns to IDLE with no rdy or ferr. A following valid 0x3C frame gives dout=0x3C.
- Framing error and break: frame 0x55 with stop bit 0, then line held low for 30 bit times → one ferr pulse, no rdy, dout holds its previous value, busy stays high. After the line goes high, frame 0x81 gives rdy with dout=0x81.
- Reset mid-frame: assert rst_n=0 during data bit 4 of a frame → outputs clear asynchronously with no rdy. The next full frame 0xC3 after release gives dout=0xC3.
